// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, ASCII command constants and byte classifier for the
// UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_MOVE = 2'd0,
        CMD_NEW  = 2'd1,
        CMD_SKIP = 2'd2,
        CMD_ERR  = 2'd3
    } cmd_kind_t;

    localparam logic [7:0] ASC_1  = 8'h31;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_r  = 8'h72;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    // Map a received byte onto the command it represents.
    function automatic cmd_kind_t cmd_classify(input logic [7:0] b);
        cmd_kind_t k;
        if (b >= ASC_1 && b <= ASC_9) begin
            k = CMD_MOVE;
        end else if (b == ASC_R || b == ASC_r) begin
            k = CMD_NEW;
        end else if (b == ASC_CR || b == ASC_LF) begin
            k = CMD_SKIP;
        end else begin
            k = CMD_ERR;
        end
        return k;
    endfunction

endpackage

// File: rtl/uart_cmd_fifo.sv
// Small synchronous byte FIFO. A push while full succeeds only when a pop
// happens in the same cycle; otherwise the byte is refused.
module uart_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [$clog2(DEPTH):0] o_count_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_dout_c  = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty_c;
    assign w_push_ok = i_push && (!o_full_c || w_pop_ok);

    // Next-cycle occupancy, also exported so the parent can register busy.
    always_comb begin
        o_count_nxt_c = r_count;
        if (w_push_ok && !w_pop_ok) begin
            o_count_nxt_c = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            o_count_nxt_c = r_count - 1'b1;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= o_count_nxt_c;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: buffers received bytes, decodes ASCII commands into
// tic-tac-toe moves / new-game requests, and hands moves to the game FSM over
// valid/ready with an acknowledge timeout.
// Optional build macro UART_CMD_ECHO_EN adds an echo_* stream of every decoded
// non-CR/LF byte; the sequencer will not fetch a new byte while an echo is pending.
module uart_cmd_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       move_valid,
    output logic [3:0] move_cell,
    input  logic       move_ready,
    output logic       new_game,
    output logic       err_cmd,
    output logic       err_timeout,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       busy
`ifdef UART_CMD_ECHO_EN
    ,
    output logic [7:0] echo_data,
    output logic       echo_valid,
    input  logic       echo_ready
`endif
);

    import uart_cmd_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cmd;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_move_valid;
    logic          w_move_valid_nxt;
    logic [3:0]    r_move_cell;
    logic [3:0]    w_move_cell_nxt;
    logic          r_new_game;
    logic          w_new_game_nxt;
    logic          r_err_cmd;
    logic          w_err_cmd_nxt;
    logic          r_err_timeout;
    logic          w_err_timeout_nxt;
    logic          r_ovf;
    logic          r_busy;
    logic          w_pop;
    logic          w_echo_block;
    logic          w_ovf_set;
    logic [7:0]    w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_cnt_nxt;
    cmd_kind_t     w_kind;

    uart_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (rx_valid),
        .i_din         (rx_data),
        .i_pop         (w_pop),
        .o_dout_c      (w_fifo_dout),
        .o_full_c      (w_fifo_full),
        .o_empty_c     (w_fifo_empty),
        .o_count_nxt_c (w_fifo_cnt_nxt)
    );

    assign w_kind    = cmd_classify(r_cmd);
    // A byte is lost only when full and nothing leaves in the same cycle.
    assign w_ovf_set = rx_valid && w_fifo_full && !w_pop;

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        w_timer_nxt       = '0;
        w_move_valid_nxt  = 1'b0;
        w_move_cell_nxt   = '0;
        w_new_game_nxt    = 1'b0;
        w_err_cmd_nxt     = 1'b0;
        w_err_timeout_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !w_echo_block) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_nxt = ST_IDLE;
                case (w_kind)
                    CMD_MOVE: begin
                        w_state_nxt      = ST_ISSUE;
                        w_move_valid_nxt = 1'b1;
                        w_move_cell_nxt  = 4'(r_cmd - ASC_1);
                    end
                    CMD_NEW:  w_new_game_nxt = 1'b1;
                    CMD_SKIP: w_state_nxt    = ST_IDLE;
                    default:  w_err_cmd_nxt  = 1'b1;
                endcase
            end
            ST_ISSUE: begin
                if (move_ready) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt       = ST_IDLE;
                    w_err_timeout_nxt = 1'b1;
                end else begin
                    w_move_valid_nxt = 1'b1;
                    w_move_cell_nxt  = r_move_cell;
                    w_timer_nxt      = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered outputs and command latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_timer       <= '0;
            r_move_valid  <= 1'b0;
            r_move_cell   <= '0;
            r_new_game    <= 1'b0;
            r_err_cmd     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            if (w_pop) begin
                r_cmd <= w_fifo_dout;
            end
            r_timer       <= w_timer_nxt;
            r_move_valid  <= w_move_valid_nxt;
            r_move_cell   <= w_move_cell_nxt;
            r_new_game    <= w_new_game_nxt;
            r_err_cmd     <= w_err_cmd_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE) || (w_fifo_cnt_nxt != '0);
        end
    end

    // Sticky overflow; a new overflow outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef UART_CMD_ECHO_EN
    logic       r_echo_valid;
    logic [7:0] r_echo_data;
    logic       w_echo_load;

    assign w_echo_load  = (r_state == ST_DECODE) && (w_kind != CMD_SKIP);
    assign w_echo_block = r_echo_valid;

    // Echo holding register, offered until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= '0;
        end else if (w_echo_load) begin
            r_echo_valid <= 1'b1;
            r_echo_data  <= r_cmd;
        end else if (echo_ready) begin
            r_echo_valid <= 1'b0;
        end
    end

    assign echo_valid = r_echo_valid;
    assign echo_data  = r_echo_data;
`else
    assign w_echo_block = 1'b0;
`endif

    assign move_valid  = r_move_valid;
    assign move_cell   = r_move_cell;
    assign new_game    = r_new_game;
    assign err_cmd     = r_err_cmd;
    assign err_timeout = r_err_timeout;
    assign ovf         = r_ovf;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized
// command bursts, checked against an event-order model of the command stream.
module tb_uart_cmd_ctrl;

    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned ACK_TIMEOUT = 8;
    localparam int EV_NEW  = 100;
    localparam int EV_ERR  = 101;
    localparam int EV_NONE = 200;
`ifdef UART_CMD_ECHO_EN
    localparam int ECHO_DLY = 1;
`else
    localparam int ECHO_DLY = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_ready;
    logic       new_game;
    logic       err_cmd;
    logic       err_timeout;
    logic       ovf;
    logic       ovf_clr;
    logic       busy;
`ifdef UART_CMD_ECHO_EN
    logic [7:0] echo_data;
    logic       echo_valid;
    logic       echo_ready;
    int         echo_q[$];
`endif

    int n_assert;
    int n_fail;
    int exp_q[$];
    int run_len;
    bit rand_ready;

    uart_cmd_ctrl #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .move_valid  (move_valid),
        .move_cell   (move_cell),
        .move_ready  (move_ready),
        .new_game    (new_game),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .busy        (busy)
`ifdef UART_CMD_ECHO_EN
        ,
        .echo_data   (echo_data),
        .echo_valid  (echo_valid),
        .echo_ready  (echo_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected event order derived from each accepted byte.
    function automatic void model_push(input logic [7:0] b);
        if (b >= 8'h31 && b <= 8'h39) exp_q.push_back(int'(b) - 'h31);
        else if (b == 8'h52 || b == 8'h72) exp_q.push_back(EV_NEW);
        else if (b != 8'h0D && b != 8'h0A) exp_q.push_back(EV_ERR);
`ifdef UART_CMD_ECHO_EN
        if (b != 8'h0D && b != 8'h0A) echo_q.push_back(int'(b));
`endif
    endfunction

    function automatic int head_ev();
        return (exp_q.size() > 0) ? exp_q[0] : EV_NONE;
    endfunction

    function automatic int pop_ev();
        int v;
        v = EV_NONE;
        if (exp_q.size() > 0) v = exp_q.pop_front();
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) move_ready = ($urandom_range(0, 5) == 0);
    endtask

    task automatic send(input logic [7:0] b, input bit modeled);
        rx_data  = b;
        rx_valid = 1'b1;
        if (modeled) model_push(b);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_move_valid"}, move_valid, 0);
        check({pfx, "_move_cell"}, move_cell, 0);
        check({pfx, "_new_game"}, new_game, 0);
        check({pfx, "_err_cmd"}, err_cmd, 0);
        check({pfx, "_err_timeout"}, err_timeout, 0);
        check({pfx, "_ovf"}, ovf, 0);
        check({pfx, "_busy"}, busy, 0);
`ifdef UART_CMD_ECHO_EN
        check({pfx, "_echo_valid"}, echo_valid, 0);
`endif
    endtask

    // Output monitor: every pulse / transfer must match the model's next event.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            run_len = 0;
        end else if (reset === 1'b0) begin
            if (move_valid !== 1'b1) begin
                check("cell_zero_when_idle", move_cell, 0);
            end else begin
                check("move_cell", move_cell, head_ev());
                if (move_ready === 1'b1) begin
                    void'(pop_ev());
                    run_len = 0;
                end else begin
                    run_len++;
                end
            end
            if (new_game === 1'b1) check("new_game_event", EV_NEW, pop_ev());
            if (err_cmd === 1'b1) check("err_cmd_event", EV_ERR, pop_ev());
            if (err_timeout === 1'b1) begin
                check("timeout_len", run_len, ACK_TIMEOUT);
                check("timeout_on_move", pop_ev() <= 8, 1);
                run_len = 0;
            end
`ifdef UART_CMD_ECHO_EN
            if (echo_valid === 1'b1 && echo_ready === 1'b1)
                check("echo_data", echo_data, (echo_q.size() > 0) ? echo_q.pop_front() : EV_NONE);
`endif
        end
    end

    initial begin
        int n;
        logic [7:0] b;
        n_assert   = 0;
        n_fail     = 0;
        run_len    = 0;
        rand_ready = 1'b0;
        reset      = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        move_ready = 1'b0;
        ovf_clr    = 1'b0;
`ifdef UART_CMD_ECHO_EN
        echo_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // '5' accepted immediately: move at N+3, single-cycle transfer.
        move_ready = 1'b1;
        send(8'h35, 1'b1);
        check("t1_busy_n1", busy, 1);
        check("t1_valid_n1", move_valid, 0);
        tick();
        check("t1_valid_n2", move_valid, 0);
        tick();
        check("t1_valid_n3", move_valid, 1);
        check("t1_cell_n3", move_cell, 4);
        tick();
        check("t1_valid_n4", move_valid, 0);
        check("t1_busy_n4", busy, 0);
        wait_idle(20, "t1_idle");

        // 'R' then 'x': one new_game pulse then one err_cmd pulse.
        send(8'h52, 1'b1);
        send(8'h78, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            check("t2_new_game", new_game, (k == 3));
            check("t2_err_cmd", err_cmd, (k == 5 + ECHO_DLY));
            check("t2_no_move", move_valid, 0);
            tick();
        end
        wait_idle(20, "t2_idle");

        // '9' never acknowledged: 8 cycles of valid then a timeout pulse.
        move_ready = 1'b0;
        send(8'h39, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            check("t3_valid", move_valid, (k >= 3 && k <= 10));
            check("t3_cell", move_cell, (k >= 3 && k <= 10) ? 8 : 0);
            check("t3_timeout", err_timeout, (k == 11));
            tick();
        end
        wait_idle(20, "t3_idle");

        // Overflow: 6 back-to-back bytes while stalled; the 6th is dropped
        // even with a same-cycle clear request.
        for (int k = 0; k < 5; k++) send(8'(8'h31 + k), 1'b1);
        check("t4_ovf_before", ovf, 0);
        ovf_clr = 1'b1;
        send(8'h36, 1'b0);
        ovf_clr = 1'b0;
        check("t4_ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", ovf, 0);
        n = 0;
        while (err_timeout !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("t4_wait_timeout", err_timeout, 1);
        send(8'h37, 1'b1);
        check("t4_full_push_pop_no_ovf", ovf, 0);
        wait_idle(300, "t4_idle");
        check("t4_queue_drained", exp_q.size(), 0);

        // Reset in the middle of an unacknowledged move.
        send(8'h35, 1'b1);
        n = 0;
        while (move_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("t5_valid_before_reset", move_valid, 1);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t5_in_reset");
        exp_q.delete();
`ifdef UART_CMD_ECHO_EN
        echo_q.delete();
`endif
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check_all_zero("t5_after_reset");
        send(8'h39, 1'b1);
        wait_idle(30, "t5_post_timeout_idle");
        check("t5_queue_drained", exp_q.size(), 0);

        // "3\r\n7": moves 2 and 6, CR/LF silent.
        move_ready = 1'b1;
        send(8'h33, 1'b1);
        send(8'h0D, 1'b1);
        send(8'h0A, 1'b1);
        send(8'h37, 1'b1);
        wait_idle(60, "t6_idle");
        check("t6_queue_drained", exp_q.size(), 0);
`ifdef UART_CMD_ECHO_EN
        check("t6_echo_drained", echo_q.size(), 0);
`endif

        // Randomized bursts with random acknowledge behaviour.
        rand_ready = 1'b1;
        for (int burst = 0; burst < 40; burst++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: b = 8'(8'h31 + $urandom_range(0, 8));
                    5:             b = 8'h52;
                    6:             b = 8'h72;
                    7:             b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
                    default:       b = 8'($urandom_range(0, 255));
                endcase
                send(b, 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle(200, "rand_idle");
        end
        rand_ready = 1'b0;
        move_ready = 1'b0;
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_no_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
